regfile_bist: RTL

//  Built-in self-test initiator for the 32x32 RegisterFile. On Start it drives
//  the register file's write port to fill registers FIRST_REG..LAST_REG with a
//  per-register pattern. It then reads them back two at a time and compares the

---
 rtl/regfile_bist.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/regfile_bist.sv
// Self-test initiator for the 32x32 register file: writes a per-register pattern, reads it back in pairs, counts mismatches.
// Optional second inverted-pattern pass is compiled in when REGFILE_BIST_INVERT_PASS_EN is defined.
module regfile_bist #(
    parameter int unsigned FIRST_REG = 8,
    parameter int unsigned LAST_REG  = 25,
    parameter logic [31:0] SEED      = 32'h0000_1234
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    output logic        Busy,
    output logic        Done,
    output logic        Pass,
    output logic [5:0]  ErrorCount,
    output logic [4:0]  FirstFailReg,
    output logic [4:0]  ReadRegister1,
    output logic [4:0]  ReadRegister2,
    output logic [4:0]  WriteRegister,
    output logic [31:0] WriteData,
    output logic        RegWrite,
    input  logic [31:0] ReadData1,
    input  logic [31:0] ReadData2
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        CHECK,
`ifdef REGFILE_BIST_INVERT_PASS_EN
        PASS2,
`endif
        DONE
    } state_t;

    localparam logic [5:0] FIRST = 6'(FIRST_REG);
    localparam logic [5:0] LAST  = 6'(LAST_REG);

    state_t      state, state_next;
    logic [5:0]  r, r_next;
`ifdef REGFILE_BIST_INVERT_PASS_EN
    logic        inv, inv_next;
`else
    localparam logic inv = 1'b0;
`endif

    logic        busy_next, done_next, pass_next, rw_next;
    logic [5:0]  err_next;
    logic [4:0]  ffr_next, rr1_next, rr2_next, wreg_next;
    logic [31:0] wdata_next;
    logic        m1, m2;
    logic [6:0]  err_sum;

    function automatic logic [31:0] pat(input logic [4:0] reg_num, input logic invert);
        logic [31:0] p;
        p = {reg_num, SEED[26:0]};
        return invert ? ~p : p;
    endfunction

    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: if (Start) state_next = WRITE;
            WRITE:      if (r == LAST) state_next = READ;
            READ:       state_next = CHECK;
            CHECK: begin
                if (r + 6'd2 > LAST) begin
`ifdef REGFILE_BIST_INVERT_PASS_EN
                    state_next = inv ? DONE : PASS2;
`else
                    state_next = DONE;
`endif
                end else begin
                    state_next = READ;
                end
            end
`ifdef REGFILE_BIST_INVERT_PASS_EN
            PASS2:      state_next = WRITE;
`endif
            default:    state_next = IDLE;
        endcase
    end

    // Outputs are the registered image of these next values, so they trail the state by one cycle.
    always_comb begin
        r_next     = r;
`ifdef REGFILE_BIST_INVERT_PASS_EN
        inv_next   = inv;
`endif
        busy_next  = 1'b0;
        done_next  = 1'b0;
        rw_next    = 1'b0;
        wreg_next  = '0;
        wdata_next = '0;
        rr1_next   = '0;
        rr2_next   = '0;
        err_next   = ErrorCount;
        ffr_next   = FirstFailReg;
        m1         = 1'b0;
        m2         = 1'b0;
        err_sum    = '0;
        case (state)
            IDLE, DONE: begin
                done_next = (state == DONE) && !Start;
                if (Start) begin
                    r_next   = FIRST;
                    err_next = '0;
                    ffr_next = '0;
`ifdef REGFILE_BIST_INVERT_PASS_EN
                    inv_next = 1'b0;
`endif
                end
            end
            WRITE: begin
                busy_next  = 1'b1;
                rw_next    = 1'b1;
                wreg_next  = r[4:0];
                wdata_next = pat(r[4:0], inv);
                r_next     = (r == LAST) ? FIRST : r + 6'd1;
            end
            READ: begin
                busy_next = 1'b1;
                rr1_next  = r[4:0];
                rr2_next  = (r == LAST) ? r[4:0] : r[4:0] + 5'd1;
            end
            CHECK: begin
                busy_next = 1'b1;
                rr1_next  = ReadRegister1;
                rr2_next  = ReadRegister2;
                m1        = ReadData1 != pat(ReadRegister1, inv);
                m2        = ReadData2 != pat(ReadRegister2, inv);
                err_sum   = 7'(ErrorCount) + 7'(m1) + 7'(m2);
                err_next  = (err_sum > 7'd63) ? 6'd63 : err_sum[5:0];
                if (FirstFailReg == '0) begin
                    if (m1)      ffr_next = ReadRegister1;
                    else if (m2) ffr_next = ReadRegister2;
                end
                r_next = r + 6'd2;
            end
`ifdef REGFILE_BIST_INVERT_PASS_EN
            PASS2: begin
                busy_next = 1'b1;
                r_next    = FIRST;
                inv_next  = 1'b1;
            end
`endif
            default: ;
        endcase
        pass_next = done_next && (err_next == '0);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r             <= '0;
`ifdef REGFILE_BIST_INVERT_PASS_EN
            inv           <= 1'b0;
`endif
            Busy          <= 1'b0;
            Done          <= 1'b0;
            Pass          <= 1'b0;
            ErrorCount    <= '0;
            FirstFailReg  <= '0;
            ReadRegister1 <= '0;
            ReadRegister2 <= '0;
            WriteRegister <= '0;
            WriteData     <= '0;
            RegWrite      <= 1'b0;
        end else begin
            r             <= r_next;
`ifdef REGFILE_BIST_INVERT_PASS_EN
            inv           <= inv_next;
`endif
            Busy          <= busy_next;
            Done          <= done_next;
            Pass          <= pass_next;
            ErrorCount    <= err_next;
            FirstFailReg  <= ffr_next;
            ReadRegister1 <= rr1_next;
            ReadRegister2 <= rr2_next;
            WriteRegister <= wreg_next;
            WriteData     <= wdata_next;
            RegWrite      <= rw_next;
        end
    end

endmodule
